// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8:1 mux round-robin arbiter.
// Optional feature macro used by the top: MUX_ARB_HOLD_LIMIT_EN.
package mux_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int N_REQ_MAX  = 8;
  localparam int HOLD_CNT_W = 8;

  // Saturating increment for the per-grant transfer counter.
  function automatic logic [HOLD_CNT_W-1:0] sat_inc(input logic [HOLD_CNT_W-1:0] v);
    logic [HOLD_CNT_W-1:0] r;
    r = (v == {HOLD_CNT_W{1'b1}}) ? v : v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Rotating-priority find-first: first set req bit searching from ptr upward,
// wrapping from N_REQ-1 back to 0. Purely combinational.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any_req
);

  logic [SEL_W-1:0] idx_s;

  // Walk the requesters in priority order and latch the first hit.
  always_comb begin
    winner  = {SEL_W{1'b0}};
    any_req = 1'b0;
    idx_s   = {SEL_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      idx_s   = ptr + SEL_W'(i);
      winner  = (!any_req && req[idx_s]) ? idx_s : winner;
      any_req = any_req | req[idx_s];
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of the 8:1 bit mux. Grants one
// requester at a time, drives the mux select, and forwards in[sel] on a
// valid/ready stream. One idle cycle separates successive grants.
// Optional macro MUX_ARB_HOLD_LIMIT_EN: force release after HOLD_MAX
// accepted transfers in one grant.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int SEL_W    = $clog2(N_REQ),
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in,
  input  logic             out_ready,
  output logic             out,
  output logic             out_valid,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  arb_state_e             state_r;
  logic [SEL_W-1:0]       ptr_r;
  logic [SEL_W-1:0]       sel_r;
  logic [N_REQ-1:0]       grant_r;
  logic [HOLD_CNT_W-1:0]  hold_cnt_r;

  logic [SEL_W-1:0]       winner_s;
  logic                   any_req_s;
  logic                   xfer_s;
  logic                   limit_hit_s;
  logic                   release_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  assign sel   = sel_r;
  assign grant = grant_r;

  // Output stream: forward the granted requester's bit while BUSY.
  always_comb begin
    busy = (state_r == BUSY);
    if (busy) begin
      out       = in[sel_r];
      out_valid = req[sel_r];
    end else begin
      out       = 1'b0;
      out_valid = 1'b0;
    end
  end

  // Transfer detection and release decision (request drop or hold limit).
  always_comb begin
    xfer_s = out_valid & out_ready;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    limit_hit_s = xfer_s && (hold_cnt_r == HOLD_CNT_W'(HOLD_MAX - 1));
`else
    limit_hit_s = 1'b0;
`endif
    release_s = busy && (!req[sel_r] || limit_hit_s);
  end

  // Arbitration FSM with registered select, grant, pointer and hold counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= {SEL_W{1'b0}};
      sel_r      <= {SEL_W{1'b0}};
      grant_r    <= {N_REQ{1'b0}};
      hold_cnt_r <= {HOLD_CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            sel_r      <= winner_s;
            grant_r    <= {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
            hold_cnt_r <= {HOLD_CNT_W{1'b0}};
            state_r    <= BUSY;
          end else begin
            state_r    <= IDLE;
          end
        end
        BUSY: begin
          if (xfer_s) begin
            hold_cnt_r <= sat_inc(hold_cnt_r);
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
          if (release_s) begin
            grant_r <= {N_REQ{1'b0}};
            ptr_r   <= sel_r + SEL_W'(1);
            state_r <= IDLE;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= {N_REQ{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural round-robin model.
// Honours MUX_ARB_HOLD_LIMIT_EN when defined.
module tb_mux8_rr_arbiter;

  localparam int N        = 8;
  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] din = 8'h00;
  logic       out_ready = 1'b0;
  logic       out;
  logic       out_valid;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_busy = 1'b0;
  int m_sel  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  mux8_rr_arbiter #(.N_REQ(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in        (din),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .sel       (sel),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge(input logic r, input logic [7:0] rq, input logic rdy);
    bit found;
    bit xfer;
    bit rel;
    int w;
    if (!r) begin
      m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      found = 1'b0; w = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && rq[(m_ptr + k) % N]) begin
          found = 1'b1;
          w = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_busy = 1'b1; m_sel = w; m_cnt = 0;
      end
    end else begin
      xfer = rq[m_sel] && rdy;
      rel  = !rq[m_sel];
`ifdef MUX_ARB_HOLD_LIMIT_EN
      if (xfer && m_cnt == HOLD_MAX - 1) rel = 1'b1;
`endif
      if (xfer && m_cnt < 255) m_cnt++;
      if (rel) begin
        m_busy = 1'b0;
        m_ptr  = (m_sel + 1) % N;
      end
    end
  endtask

  // One cycle: drive inputs on the falling edge, compare, then let the edge happen.
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    rst_n = r; req = rq; din = d; out_ready = rdy;
    #1;
    check("busy",      busy,      m_busy);
    check("grant",     grant,     m_busy ? (32'd1 << m_sel) : 32'd0);
    check("sel",       sel,       m_sel);
    check("out_valid", out_valid, m_busy ? rq[m_sel] : 1'b0);
    check("out",       out,       m_busy ? d[m_sel] : 1'b0);
    @(posedge clk);
    model_edge(r, rq, rdy);
    #1;
  endtask

  initial begin
    logic [7:0] rq_r;

    // 1: reset with all requests high, then first grant goes to requester 0
    step(1'b0, 8'hFF, 8'h00, 1'b0);
    step(1'b0, 8'hFF, 8'h00, 1'b0);
    check("t1_rst_grant", grant, 8'h00);
    check("t1_rst_valid", out_valid, 1'b0);
    check("t1_rst_sel", sel, 3'd0);
    step(1'b1, 8'hFF, 8'h00, 1'b0);
    check("t1_first_grant", grant, 8'h01);

    // 2: two requesters from ptr 0, handover through one idle cycle
    step(1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'b0010_0100, 8'h00, 1'b0);
    check("t2_grant2", grant, 8'h04);
    check("t2_sel2", sel, 3'd2);
    step(1'b1, 8'b0010_0000, 8'h00, 1'b0);
    check("t2_idle_grant", grant, 8'h00);
    check("t2_idle_sel", sel, 3'd2);
    step(1'b1, 8'b0010_0000, 8'h00, 1'b0);
    check("t2_grant5", grant, 8'h20);
    check("t2_sel5", sel, 3'd5);

    // 3: backpressure keeps data and grant stable
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h20, 8'h20, 1'b0);
      check("t3_valid", out_valid, 1'b1);
      check("t3_out", out, 1'b1);
      check("t3_grant", grant, 8'h20);
    end

    // 4: pointer at 7 wraps back to 0
    step(1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'h40, 8'h00, 1'b0);
    step(1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'h81, 8'h00, 1'b0);
    check("t4_grant7", grant, 8'h80);
    check("t4_sel7", sel, 3'd7);
    step(1'b1, 8'h01, 8'h00, 1'b0);
    check("t4_release", grant, 8'h00);
    step(1'b1, 8'h01, 8'h00, 1'b0);
    check("t4_wrap_grant0", grant, 8'h01);

`ifdef MUX_ARB_HOLD_LIMIT_EN
    // 5: hold limit forces a handover after HOLD_MAX transfers
    step(1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'h03, 8'hFF, 1'b1);
    check("t5_grant0", grant, 8'h01);
    for (int i = 0; i < HOLD_MAX; i++) step(1'b1, 8'h03, 8'hFF, 1'b1);
    check("t5_forced_idle", grant, 8'h00);
    step(1'b1, 8'h03, 8'hFF, 1'b1);
    check("t5_grant1", grant, 8'h02);
`endif

    // 6: reset during an active transfer
    step(1'b1, 8'h10, 8'h10, 1'b0);
    step(1'b1, 8'h10, 8'h10, 1'b0);
    step(1'b0, 8'h10, 8'h10, 1'b1);
    check("t6_grant", grant, 8'h00);
    check("t6_valid", out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    step(1'b1, 8'hFF, 8'h00, 1'b0);
    check("t6_ptr0_grant", grant, 8'h01);

    // Random traffic with persistent request levels
    rq_r = 8'h00;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) rq_r[b] = ~rq_r[b];
      end
      step(($urandom_range(0, 63) != 0), rq_r, 8'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
